// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubbles and valid/ready flow control.
// Define ID_EX_FORWARDING_EN to forward from EX, EX/MEM and MEM/WB; otherwise hazards stall until writers retire.
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    output logic                      id_ready,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
    input  logic [DATA_WIDTH-1:0]     id_data_rs1,
    input  logic [DATA_WIDTH-1:0]     id_data_rs2,
    input  logic [DATA_WIDTH-1:0]     id_imm,
    input  logic                      id_alu_src,
    input  logic [1:0]                id_alu_inst,
    input  logic                      id_reg_write,
    input  logic                      id_mem_read,
    input  logic                      id_mem_write,
    input  logic                      id_branch,
    input  logic                      flush,
    input  logic                      ex_ready,
    input  logic [DATA_WIDTH-1:0]     alu_result,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd_addr,
    input  logic                      exmem_reg_write,
    input  logic [DATA_WIDTH-1:0]     exmem_result,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd_addr,
    input  logic                      memwb_reg_write,
    input  logic [DATA_WIDTH-1:0]     memwb_result,
    output logic                      ex_valid,
    output logic [DATA_WIDTH-1:0]     data_rs1,
    output logic [DATA_WIDTH-1:0]     source_2,
    output logic [1:0]                alu_inst,
    output logic [DATA_WIDTH-1:0]     ex_store_data,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    output logic                      ex_reg_write,
    output logic                      ex_mem_read,
    output logic                      ex_mem_write,
    output logic                      ex_branch
);

    logic                  advance;
    logic                  hazard;
    logic                  rs2_used;
    logic [DATA_WIDTH-1:0] fwd_rs1;
    logic [DATA_WIDTH-1:0] fwd_rs2;

    assign advance  = !ex_valid || ex_ready;
    assign rs2_used = !id_alu_src || id_mem_write || id_branch;
    assign id_ready = advance && !hazard;

    // Register 0 is hard-wired, so it never matches any writer.
    function automatic logic addr_hit(input logic [REG_ADDR_WIDTH-1:0] writer,
                                      input logic [REG_ADDR_WIDTH-1:0] src);
        return (src != '0) && (writer == src);
    endfunction

`ifdef ID_EX_FORWARDING_EN
    function automatic logic [DATA_WIDTH-1:0] forward(input logic [REG_ADDR_WIDTH-1:0] src,
                                                      input logic [DATA_WIDTH-1:0]     rf);
        if (ex_valid && ex_reg_write && !ex_mem_read && addr_hit(ex_rd_addr, src))
            return alu_result;
        else if (exmem_reg_write && addr_hit(exmem_rd_addr, src))
            return exmem_result;
        else if (memwb_reg_write && addr_hit(memwb_rd_addr, src))
            return memwb_result;
        else
            return rf;
    endfunction

    always_comb begin
        hazard = 1'b0;
        if (ex_valid && ex_mem_read)
            hazard = addr_hit(ex_rd_addr, id_rs1_addr) ||
                     (rs2_used && addr_hit(ex_rd_addr, id_rs2_addr));
    end

    assign fwd_rs1 = forward(id_rs1_addr, id_data_rs1);
    assign fwd_rs2 = forward(id_rs2_addr, id_data_rs2);
`else
    // Without forwarding, any pending writer of a used source must retire first.
    function automatic logic pending(input logic [REG_ADDR_WIDTH-1:0] src);
        return (ex_valid && ex_reg_write && addr_hit(ex_rd_addr, src)) ||
               (exmem_reg_write && addr_hit(exmem_rd_addr, src)) ||
               (memwb_reg_write && addr_hit(memwb_rd_addr, src));
    endfunction

    logic unused_fwd_data;

    assign hazard          = pending(id_rs1_addr) || (rs2_used && pending(id_rs2_addr));
    assign fwd_rs1         = id_data_rs1;
    assign fwd_rs2         = id_data_rs2;
    assign unused_fwd_data = ^{alu_result, exmem_result, memwb_result};
`endif

    always_ff @(posedge clk) begin
        if (rst || flush || (advance && !(id_valid && id_ready))) begin
            ex_valid      <= 1'b0;
            data_rs1      <= '0;
            source_2      <= '0;
            alu_inst      <= '0;
            ex_store_data <= '0;
            ex_rd_addr    <= '0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_branch     <= 1'b0;
        end else if (advance) begin
            ex_valid      <= 1'b1;
            data_rs1      <= fwd_rs1;
            source_2      <= id_alu_src ? id_imm : fwd_rs2;
            alu_inst      <= id_alu_inst;
            ex_store_data <= fwd_rs2;
            ex_rd_addr    <= id_rd_addr;
            ex_reg_write  <= id_reg_write;
            ex_mem_read   <= id_mem_read;
            ex_mem_write  <= id_mem_write;
            ex_branch     <= id_branch;
        end
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register feeding the ALU: captures decoded operands and control from the decode stage and presents `data_rs1`, `source_2` and `alu_inst` to the ALU one cycle later. Resolves operand forwarding from the in-flight ALU result, EX/MEM and MEM/WB. Inserts load-use bubbles and honours a valid/ready handshake with stall and flush.

## Interface
- `DATA_WIDTH`, 32, operand/result width
- `REG_ADDR_WIDTH`, 5, register index width
- Clock is `clk`; reset is `rst`, synchronous, active-high.
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous active-high reset
- `id_valid`  in  1  decode holds a valid instruction
- `id_ready`  out  1  stage accepts the decode instruction this cycle
- `id_rs1_addr`, `id_rs2_addr`, `id_rd_addr`  in  REG_ADDR_WIDTH  source/dest indices
- `id_data_rs1`, `id_data_rs2`  in  DATA_WIDTH  register-file read data
- `id_imm`  in  DATA_WIDTH  sign-extended immediate
- `id_alu_src`  in  1  1 = `source_2` takes immediate
- `id_alu_inst`  in  2  00 add, 01 sub, 10 and, 11 or
- `id_reg_write`, `id_mem_read`, `id_mem_write`, `id_branch`  in  1 each  control
- `flush`  in  1  kill the instruction in this stage
- `ex_ready`  in  1  downstream consumes EX contents this cycle
- `alu_result`  in  DATA_WIDTH  current ALU output, the forwarding source
- `exmem_rd_addr`, `exmem_reg_write`, `exmem_result`  in  5/1/DATA_WIDTH  EX/MEM writer
- `memwb_rd_addr`, `memwb_reg_write`, `memwb_result`  in  5/1/DATA_WIDTH  MEM/WB writer
- `ex_valid`  out  1  EX register holds a valid instruction
- `data_rs1`, `source_2`  out  DATA_WIDTH  ALU operands
- `alu_inst`  out  2  ALU opcode
- `ex_store_data`  out  DATA_WIDTH  forwarded rs2 value for stores
- `ex_rd_addr`  out  REG_ADDR_WIDTH; `ex_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_branch`  out  1 each

## Operation
- The stage is one register set plus `ex_valid`. It loads when `advance = !ex_valid || ex_ready`.
- Load-use hazard: `ex_valid && ex_mem_read && ex_rd_addr != 0` and (`id_rs1_addr == ex_rd_addr`, or `id_rs2_addr == ex_rd_addr` with rs2 used). rs2 is used when `!id_alu_src || id_mem_write || id_branch`.
- `id_ready = advance && !hazard`.
- On advance:
  - If `id_valid && id_ready`, capture the instruction and set `ex_valid` = 1.
  - Otherwise load a bubble: `ex_valid` = 0 and every control output = 0.
- Not advancing: all outputs hold.
- `flush` = 1: next `ex_valid` = 0 and controls = 0, regardless of advance or hold. `id_ready` is still computed as above; an instruction accepted while `flush` is asserted is discarded.
- Forwarding per source register, decided at capture. Priority, first match wins:
  - in-flight EX (`ex_valid && ex_reg_write && !ex_mem_read && ex_rd_addr == src`) → `alu_result`
  - EX/MEM match with `exmem_reg_write` → `exmem_result`
  - MEM/WB match with `memwb_reg_write` → `memwb_result`
  - otherwise register-file data
- Register 0 never matches; it always uses register-file data.
- `source_2 = id_alu_src ? id_imm : fwd_rs2`. `ex_store_data = fwd_rs2` always.

## Timing
- Reset (`rst` = 1 at an edge): every output register is 0, including `ex_valid`, `data_rs1`, `source_2`, `alu_inst` (= add) and all control bits. `id_ready` after reset is 1.
- Latency is 1 cycle from accepted decode to EX outputs. Throughput is 1 instruction/cycle with no hazard and `ex_ready` = 1.
- A load-use hazard costs exactly one bubble. On the next cycle the load has left EX and the dependent instruction is accepted, forwarding from EX/MEM or MEM/WB.
- `ex_ready` = 0 with `ex_valid` = 1: the stage holds indefinitely and `id_ready` = 0.
- `id_ready` is combinational from the current state and the `id_*` inputs. `id_valid` must not depend on `id_ready`.
- Precedence for the same edge: `rst` > `flush` > load/hold.

## Configuration
- `ID_EX_FORWARDING_EN` defined: forwarding as above, with the load-use hazard only.
- Not defined: operands always come from register-file data.
  - The hazard widens to any used-source match (non-zero, writer's reg_write = 1) against the valid EX instruction, the EX/MEM writer or the MEM/WB writer.
  - The register file is write-first, so no stall is needed after MEM/WB.
  - Forwarding ports remain but are ignored.

## Test plan
- Reset then idle: `rst` 1 for 2 cycles → all outputs 0, `id_ready` = 1. `id_valid` = 0 → `ex_valid` stays 0.
- Back-to-back ALU dependency: `add x3` (result 0x10) then `sub x4,x3,x1` with `id_data_rs1` = 0xDEAD → second `data_rs1` = 0x10 from `alu_result`. Without the macro: stall until x3 retires, then 0x10 from the register file.
- Load-use: `lw x5` in EX, decode `and x6,x5,x2` → `id_ready` = 0 for one cycle, one bubble (`ex_valid` = 0), then accept with `data_rs1 = exmem_result`.
- Priority and x0: EX/MEM and MEM/WB both write x7 (0x1, 0x2) → 0x1 chosen. A source of x0 with EX/MEM writing x0 → register-file value used.
- Immediate and store: `id_alu_src` = 1, `id_imm` = 0xFFFFFFFC, rs2 forwarded 0x55 → `source_2` = 0xFFFFFFFC, `ex_store_data` = 0x55.
- Backpressure and flush:
  - `ex_ready` = 0 for 3 cycles → outputs frozen, `id_ready` = 0.
  - `flush` together with `id_valid` → `ex_valid` = 0 next cycle and the instruction is dropped.
